// File: rtl/fpalu_pkg.sv
// Shared FPALU constants and types: format widths, exponent biases and
// binary16 special encodings used by the unified<->binary16 converters.
package fpalu_pkg;

  localparam int ML_EXPSIZE   = 5;
  localparam int ML_MANSIZE   = 11;
  localparam int AL_EXPSIZE   = 6;
  localparam int AL_MANSIZE   = 22;
  localparam int UNI_EXPBIAS  = 31;
  localparam int FP16_EXPBIAS = 15;

  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] MAX_FIN = 16'h7BFF;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
  } flags_t;

endpackage

// File: rtl/fpalu_lzd22.sv
// Combinational leading-zero count over the unified mantissa width;
// an all-zero input reports the full width.
module fpalu_lzd22
  import fpalu_pkg::*;
(
  input  logic [AL_MANSIZE-1:0]         vec,
  output logic [$clog2(AL_MANSIZE+1)-1:0] cnt
);

  localparam int CW = $clog2(AL_MANSIZE + 1);

  // Later (higher) set bits overwrite earlier ones, so the MSB-most one wins.
  always_comb begin
    cnt = CW'(AL_MANSIZE);
    for (int i = 0; i < AL_MANSIZE; i++) begin
      if (vec[i]) cnt = CW'(AL_MANSIZE - 1 - i);
    end
  end

endmodule

// File: rtl/fpalu_uni2fp16.sv
// Unified (sign, biased 6b exp, right-aligned 22b mantissa) to IEEE binary16
// converter: 3-stage valid/ready pipeline with RNE rounding and flags.
module fpalu_uni2fp16
  import fpalu_pkg::*;
#(
  parameter bit SATURATE     = 1'b0,
  parameter int UNI_EXPBIAS  = fpalu_pkg::UNI_EXPBIAS,
  parameter int FP16_EXPBIAS = fpalu_pkg::FP16_EXPBIAS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sgn,
  input  logic [AL_EXPSIZE-1:0] in_exp,
  input  logic [AL_MANSIZE-1:0] in_man_dn,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_fp16,
  output logic                  out_ovf,
  output logic                  out_unf,
  output logic                  out_inx
);

  localparam int FW = ML_MANSIZE - 1;
  localparam int SW = AL_MANSIZE - 1;
  localparam logic signed [7:0] E_ADJ   = 8'(FP16_EXPBIAS - UNI_EXPBIAS - 1);
  localparam logic signed [7:0] EXP_MAX = 8'((1 << ML_EXPSIZE) - 1);

  function automatic logic [FW:0] rne_round(input logic [FW-1:0] frac,
                                            input logic g, input logic s);
    logic inc;
    inc = g & (s | frac[0]);
    return {1'b0, frac} + (FW+1)'(inc);
  endfunction

  function automatic logic [15:0] ovf_value(input logic sgn);
    return SATURATE ? {sgn, MAX_FIN[14:0]} : {sgn, POS_INF[14:0]};
  endfunction

  logic vld_p1, vld_p2;
  logic ready_p1, ready_p2, ready_p3;

  assign ready_p3 = ~out_valid | out_ready;
  assign ready_p2 = ~vld_p2 | ready_p3;
  assign ready_p1 = ~vld_p1 | ready_p2;
  assign in_ready = ready_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (ready_p1) vld_p1    <= in_valid;
      if (ready_p2) vld_p2    <= vld_p1;
      if (ready_p3) out_valid <= vld_p2;
    end
  end

  // ---- stage 1: capture input word, leading-zero detect ----
  logic                  sgn_p1;
  logic [AL_EXPSIZE-1:0] exp_p1;
  logic [AL_MANSIZE-1:0] man_p1;
  logic [4:0]            lz;

  always_ff @(posedge clk) begin
    if (ready_p1 && in_valid) begin
      sgn_p1 <= in_sgn;
      exp_p1 <= in_exp;
      man_p1 <= in_man_dn;
    end
  end

  fpalu_lzd22 u_lzd (
    .vec (man_p1),
    .cnt (lz)
  );

  // ---- stage 2: normalize, denormalize into the subnormal range ----
  logic signed [7:0]       e_norm, e_neg;
  logic [AL_MANSIZE-1:0]   sig_norm;
  logic [4:0]              sub_shm1;
  logic [2*AL_MANSIZE-1:0] sub_ext;
  logic                    tiny;

  // Shifting {sig,22'b0} by (1-E)-1 equals shifting {sig,23'b0} by 1-E with
  // the always-zero top bit dropped; 22 here is the 23-bit cap minus one.
  always_comb begin
    e_norm   = $signed({2'b00, exp_p1}) - $signed({3'b000, lz}) + E_ADJ;
    e_neg    = 8'sd0 - e_norm;
    sig_norm = man_p1 << lz;
    sub_shm1 = (e_neg > 8'sd22) ? 5'd22 : e_neg[4:0];
    sub_ext  = {sig_norm, {AL_MANSIZE{1'b0}}} >> sub_shm1;
    tiny     = (e_norm <= 8'sd0);
  end

  logic              sgn_p2, zero_p2, tiny_p2, sticky_p2;
  logic signed [7:0] ebase_p2;
  logic [SW-1:0]     sig_p2;

  always_ff @(posedge clk) begin
    if (ready_p2 && vld_p1) begin
      sgn_p2    <= sgn_p1;
      zero_p2   <= (man_p1 == '0);
      tiny_p2   <= tiny;
      ebase_p2  <= tiny ? 8'sd0 : e_norm;
      sig_p2    <= tiny ? sub_ext[2*AL_MANSIZE-1:AL_MANSIZE+1] : sig_norm[SW-1:0];
      sticky_p2 <= tiny ? (|sub_ext[AL_MANSIZE:0]) : 1'b0;
    end
  end

  // ---- stage 3: round to nearest even, pack, flag ----
  logic [FW-1:0]     frac;
  logic              g_bit, s_bit;
  logic [FW:0]       rnd;
  logic signed [7:0] exp_fin;
  logic [15:0]       res;
  flags_t            flg;

  always_comb begin
    frac    = sig_p2[SW-1:SW-FW];
    g_bit   = sig_p2[SW-FW-1];
    s_bit   = (|sig_p2[SW-FW-2:0]) | sticky_p2;
    rnd     = rne_round(frac, g_bit, s_bit);
    exp_fin = ebase_p2 + $signed({7'b0, rnd[FW]});
    res     = {sgn_p2, exp_fin[4:0], rnd[FW-1:0]};
    flg.ovf = 1'b0;
    flg.inx = g_bit | s_bit;
    flg.unf = tiny_p2 & (g_bit | s_bit);
    if (zero_p2) begin
      res = {sgn_p2, 15'b0};
      flg = '0;
    end else if (exp_fin >= EXP_MAX) begin
      res     = ovf_value(sgn_p2);
      flg.ovf = 1'b1;
      flg.inx = 1'b1;
      flg.unf = tiny_p2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_fp16 <= '0;
      out_ovf  <= 1'b0;
      out_unf  <= 1'b0;
      out_inx  <= 1'b0;
    end else if (ready_p3 && vld_p2) begin
      out_fp16 <= res;
      out_ovf  <= flg.ovf;
      out_unf  <= flg.unf;
      out_inx  <= flg.inx;
    end
  end

endmodule

// File: tb/tb_fpalu_uni2fp16.sv
// Directed bench for fpalu_uni2fp16: two instances (infinity and saturating
// overflow) driven by the same stimulus, checked against hand-computed vectors.
module tb_fpalu_uni2fp16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sgn = 1'b0;
  logic [5:0]  in_exp = '0;
  logic [21:0] in_man_dn = '0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, ovf0, unf0, inx0;
  logic [15:0] fp0;
  logic        in_ready1, out_valid1, ovf1, unf1, inx1;
  logic [15:0] fp1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fpalu_uni2fp16 #(.SATURATE(1'b0)) dut_inf (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_sgn(in_sgn), .in_exp(in_exp), .in_man_dn(in_man_dn),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_fp16(fp0), .out_ovf(ovf0), .out_unf(unf0), .out_inx(inx0)
  );

  fpalu_uni2fp16 #(.SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_sgn(in_sgn), .in_exp(in_exp), .in_man_dn(in_man_dn),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_fp16(fp1), .out_ovf(ovf1), .out_unf(unf1), .out_inx(inx1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One isolated word; fl = {ovf,unf,inx}. r1 is the saturating instance's result.
  task automatic run_vec(input string tag, input logic s, input logic [5:0] e,
                         input logic [21:0] m, input logic [15:0] r0,
                         input logic [15:0] r1, input logic [2:0] fl);
    int waited;
    bit seen;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sgn    = s;
    in_exp    = e;
    in_man_dn = m;
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 10) begin
      @(negedge clk);
      waited++;
      seen = out_valid0;
    end
    check({tag, "_lat"}, waited, 2);
    check({tag, "_fp16"}, fp0, r0);
    check({tag, "_fp16_sat"}, fp1, r1);
    check({tag, "_flags"}, {ovf0, unf0, inx0}, fl);
    check({tag, "_flags_sat"}, {ovf1, unf1, inx1}, fl);
    check({tag, "_vld_sat"}, out_valid1, 1);
    @(negedge clk);
    check({tag, "_drain"}, out_valid0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_q[$];
    int na, nr, n_stale;
    bit drop_seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_vld", out_valid0, 0);
    check("rst_fp16", fp0, 0);
    check("rst_flags", {ovf0, unf0, inx0}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rdy", in_ready0, 1);
    check("rst_rdy_sat", in_ready1, 1);

    // Directed vectors: tag, sgn, exp, man, inf result, sat result, {ovf,unf,inx}
    run_vec("one",       1'b0, 6'd32, 22'h200000, 16'h3C00, 16'h3C00, 3'b000);
    run_vec("neg1p5",    1'b1, 6'd32, 22'h300000, 16'hBE00, 16'hBE00, 3'b000);
    run_vec("tie_even",  1'b0, 6'd32, 22'h200400, 16'h3C00, 16'h3C00, 3'b001);
    run_vec("tie_up",    1'b0, 6'd32, 22'h200C00, 16'h3C02, 16'h3C02, 3'b001);
    run_vec("sub_min",   1'b0, 6'd8,  22'h200000, 16'h0001, 16'h0001, 3'b000);
    run_vec("sub_rnd",   1'b0, 6'd8,  22'h180000, 16'h0001, 16'h0001, 3'b011);
    run_vec("neg_zero",  1'b1, 6'd20, 22'h000000, 16'h8000, 16'h8000, 3'b000);
    run_vec("ovf",       1'b0, 6'd63, 22'h200000, 16'h7C00, 16'h7BFF, 3'b101);
    run_vec("ovf_neg",   1'b1, 6'd63, 22'h200000, 16'hFC00, 16'hFBFF, 3'b101);
    run_vec("sub2norm",  1'b0, 6'd17, 22'h3FFFFF, 16'h0400, 16'h0400, 3'b011);
    run_vec("rnd2ovf",   1'b0, 6'd47, 22'h3FFFFF, 16'h7C00, 16'h7BFF, 3'b101);
    run_vec("max_fin",   1'b0, 6'd47, 22'h3FF800, 16'h7BFF, 16'h7BFF, 3'b000);
    run_vec("exp0_tiny", 1'b1, 6'd0,  22'h000001, 16'h8000, 16'h8000, 3'b011);

    // Backpressure: 6 back-to-back words, out_ready low for the first 5 cycles
    na = 0;
    nr = 0;
    drop_seen = 1'b0;
    for (int cyc = 0; cyc < 40 && nr < 6; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (na < 6);
      in_sgn    = 1'b0;
      in_exp    = 6'd32;
      in_man_dn = 22'h200000 | (22'(na + 1) << 11);
      #1;
      if (!drop_seen && !in_ready0) begin
        drop_seen = 1'b1;
        check("bp_drop_after", na, 3);
      end
      if (out_valid0 && !out_ready) check("bp_hold", fp0, 16'h3C01);
      if (cyc == 5) check("bp_nobubble", in_ready0, 1);
      if (out_valid0 && out_ready) begin
        if (exp_q.size() == 0) check("bp_extra_out", fp0, 16'hFFFF);
        else check("bp_out", fp0, exp_q.pop_front());
        nr++;
      end
      if (in_valid && in_ready0) begin
        exp_q.push_back(16'h3C00 + 16'(na + 1));
        na++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("bp_count_in", na, 6);
    check("bp_count_out", nr, 6);
    check("bp_drop_seen", drop_seen, 1);
    check("bp_empty", out_valid0, 0);

    // Reset with three words in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sgn    = 1'b0;
      in_exp    = 6'd32;
      in_man_dn = 22'h200000 | (22'(k + 1) << 11);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("mrst_pre_vld", out_valid0, 1);
    rst = 1'b1;
    #1;
    check("mrst_vld", out_valid0, 0);
    check("mrst_fp16", fp0, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    n_stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid0) n_stale++;
    end
    check("mrst_stale", n_stale, 0);
    run_vec("post_rst", 1'b0, 6'd32, 22'h300000, 16'h3E00, 16'h3E00, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
